// File: rtl/fft_stage_pkg.sv
// fft_stage_pkg: shared constants, lane/chunk types and helpers for the FFT
// stage-1 input buffer (cbfp_pair_buffer and its pair_store).
package fft_stage_pkg;

  localparam int NUM_PARALLEL_PATHS = 16;
  localparam int WIDTH              = 11;
  localparam int IDX_WIDTH          = 5;
  localparam int BLOCK_SIZE         = 512;
  localparam int NUM_CHUNKS         = BLOCK_SIZE / NUM_PARALLEL_PATHS;
  localparam int HALF_CHUNKS        = NUM_CHUNKS / 2;
  localparam int CNT_WIDTH          = $clog2(NUM_CHUNKS);
  localparam int SLOT_WIDTH         = $clog2(HALF_CHUNKS);

  // Largest useful arithmetic shift; anything beyond leaves only sign bits.
  localparam logic [IDX_WIDTH-1:0] MAX_SHIFT = IDX_WIDTH'(WIDTH - 1);

  // One lane: complex sample plus its CBFP exponent index (27 bits).
  typedef struct packed {
    logic signed [WIDTH-1:0] re;
    logic signed [WIDTH-1:0] im;
    logic [IDX_WIDTH-1:0]    index;
  } lane_t;

  typedef lane_t [0:NUM_PARALLEL_PATHS-1] chunk_t;

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_PAIR = 1'b1
  } state_t;

  // Arithmetic right shift with the shift amount clamped to WIDTH-1.
  function automatic logic signed [WIDTH-1:0] asr_clamp(
    input logic signed [WIDTH-1:0] value,
    input logic [IDX_WIDTH-1:0]    shift
  );
    logic [IDX_WIDTH-1:0] sh;
    sh = (shift > MAX_SHIFT) ? MAX_SHIFT : shift;
    return value >>> sh;
  endfunction

endpackage

// File: rtl/cbfp_pair_buffer_pair_store.sv
// pair_store: 16-entry chunk store holding the first half of a frame.
// One write port, one asynchronous read port; storage is not reset.
module pair_store
  import fft_stage_pkg::*;
(
  input  logic                  clk,
  input  logic                  i_wr_en,
  input  logic [SLOT_WIDTH-1:0] i_wr_addr,
  input  chunk_t                i_wr_data,
  input  logic [SLOT_WIDTH-1:0] i_rd_addr,
  output chunk_t                o_rd_data
);

  chunk_t r_mem [0:HALF_CHUNKS-1];

  // Write the incoming first-half chunk into its slot.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/cbfp_pair_buffer.sv
// cbfp_pair_buffer: stage-1 input buffer. Stores chunks 0..15 of each
// 512-point frame, then emits (chunk k, chunk k+16) butterfly operand pairs
// as chunks 16..31 arrive. Latency 1 clk from the b-chunk to the pair.
// Optional macro INDEX_ALIGN_EN: align each lane pair to the smaller index
// by shifting the larger-index operand; adds one pipeline register.
//
// state   | meaning
// ST_FILL | cnt 0..15, incoming chunk written to slot cnt[3:0]
// ST_PAIR | cnt 16..31, slot cnt[3:0] paired with the incoming chunk
module cbfp_pair_buffer
  import fft_stage_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        di_en,
  input  logic signed [WIDTH-1:0]     di_re      [0:NUM_PARALLEL_PATHS-1],
  input  logic signed [WIDTH-1:0]     di_im      [0:NUM_PARALLEL_PATHS-1],
  input  logic        [IDX_WIDTH-1:0] di_index   [0:NUM_PARALLEL_PATHS-1],
  output logic                        do_en,
  output logic signed [WIDTH-1:0]     do_a_re    [0:NUM_PARALLEL_PATHS-1],
  output logic signed [WIDTH-1:0]     do_a_im    [0:NUM_PARALLEL_PATHS-1],
  output logic signed [WIDTH-1:0]     do_b_re    [0:NUM_PARALLEL_PATHS-1],
  output logic signed [WIDTH-1:0]     do_b_im    [0:NUM_PARALLEL_PATHS-1],
  output logic        [IDX_WIDTH-1:0] do_a_index [0:NUM_PARALLEL_PATHS-1],
  output logic        [IDX_WIDTH-1:0] do_b_index [0:NUM_PARALLEL_PATHS-1],
  output logic        [SLOT_WIDTH-1:0] do_pair,
  output logic                        do_last
);

  logic [CNT_WIDTH-1:0]  r_cnt;
  state_t                w_state;
  logic                  w_wr_en;
  chunk_t                w_in_chunk;
  chunk_t                w_rd_chunk;

  chunk_t                r_a;
  chunk_t                r_b;
  logic                  r_en;
  logic                  r_last;
  logic [SLOT_WIDTH-1:0] r_pair;

  chunk_t                w_out_a;
  chunk_t                w_out_b;
  logic                  w_out_en;
  logic                  w_out_last;
  logic [SLOT_WIDTH-1:0] w_out_pair;

  // The upper counter bit selects the half of the frame being received.
  assign w_state = r_cnt[CNT_WIDTH-1] ? ST_PAIR : ST_FILL;
  assign w_wr_en = di_en && (w_state == ST_FILL);

  // Gather the per-lane input ports into one chunk word.
  always_comb begin
    w_in_chunk = '0;
    for (int l = 0; l < NUM_PARALLEL_PATHS; l++) begin
      w_in_chunk[l].re    = di_re[l];
      w_in_chunk[l].im    = di_im[l];
      w_in_chunk[l].index = di_index[l];
    end
  end

  // Slot k is read at cnt=16+k and rewritten only at cnt=k of the next
  // frame, so the same address serves both ports without a hazard.
  pair_store u_pair_store (
    .clk       (clk),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (r_cnt[SLOT_WIDTH-1:0]),
    .i_wr_data (w_in_chunk),
    .i_rd_addr (r_cnt[SLOT_WIDTH-1:0]),
    .o_rd_data (w_rd_chunk)
  );

  // Chunk counter, fill/pair sequencing and the registered operand pair.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_en   <= 1'b0;
      r_last <= 1'b0;
      r_pair <= '0;
      r_a    <= '0;
      r_b    <= '0;
    end else begin
      r_en   <= 1'b0;
      r_last <= 1'b0;
      if (di_en) begin
        r_cnt <= r_cnt + 1'b1;
        case (w_state)
          ST_FILL: begin
          end
          ST_PAIR: begin
            r_en   <= 1'b1;
            r_pair <= r_cnt[SLOT_WIDTH-1:0];
            r_last <= (r_cnt == CNT_WIDTH'(NUM_CHUNKS - 1));
            r_a    <= w_rd_chunk;
            r_b    <= w_in_chunk;
          end
          default: begin
          end
        endcase
      end
    end
  end

`ifdef INDEX_ALIGN_EN
  chunk_t                w_al_a;
  chunk_t                w_al_b;
  chunk_t                r_al_a;
  chunk_t                r_al_b;
  logic                  r_al_en;
  logic                  r_al_last;
  logic [SLOT_WIDTH-1:0] r_al_pair;

  // Bring both operands of each lane to the smaller exponent index.
  always_comb begin
    w_al_a = r_a;
    w_al_b = r_b;
    for (int l = 0; l < NUM_PARALLEL_PATHS; l++) begin
      if (r_a[l].index > r_b[l].index) begin
        w_al_a[l].re    = asr_clamp(r_a[l].re, r_a[l].index - r_b[l].index);
        w_al_a[l].im    = asr_clamp(r_a[l].im, r_a[l].index - r_b[l].index);
        w_al_a[l].index = r_b[l].index;
      end else begin
        w_al_b[l].re    = asr_clamp(r_b[l].re, r_b[l].index - r_a[l].index);
        w_al_b[l].im    = asr_clamp(r_b[l].im, r_b[l].index - r_a[l].index);
        w_al_b[l].index = r_a[l].index;
      end
    end
  end

  // Extra pipeline stage; data holds between pairs, strobes are delayed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_al_a    <= '0;
      r_al_b    <= '0;
      r_al_en   <= 1'b0;
      r_al_last <= 1'b0;
      r_al_pair <= '0;
    end else begin
      r_al_en   <= r_en;
      r_al_last <= r_last;
      if (r_en) begin
        r_al_a    <= w_al_a;
        r_al_b    <= w_al_b;
        r_al_pair <= r_pair;
      end
    end
  end

  assign w_out_a    = r_al_a;
  assign w_out_b    = r_al_b;
  assign w_out_en   = r_al_en;
  assign w_out_last = r_al_last;
  assign w_out_pair = r_al_pair;
`else
  assign w_out_a    = r_a;
  assign w_out_b    = r_b;
  assign w_out_en   = r_en;
  assign w_out_last = r_last;
  assign w_out_pair = r_pair;
`endif

  assign do_en   = w_out_en;
  assign do_last = w_out_last;
  assign do_pair = w_out_pair;

  // Spread the registered chunks back onto the per-lane output ports.
  always_comb begin
    for (int l = 0; l < NUM_PARALLEL_PATHS; l++) begin
      do_a_re[l]    = w_out_a[l].re;
      do_a_im[l]    = w_out_a[l].im;
      do_a_index[l] = w_out_a[l].index;
      do_b_re[l]    = w_out_b[l].re;
      do_b_im[l]    = w_out_b[l].im;
      do_b_index[l] = w_out_b[l].index;
    end
  end

endmodule
